slow_fast_xfer: RTL and testbench

SLOW_FAST_XFER -- requirements
Module: slow_fast_xfer

---
 rtl/slow_fast_pkg.sv | 15 +
 rtl/sf_fifo.sv | 69 ++++++
 rtl/slow_fast_xfer.sv | 147 ++++++++++++++
 tb/tb_slow_fast_xfer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_fast_pkg.sv
// Shared definitions for the slow-to-fast sample transfer block:
// capture FSM state encoding and default geometry constants.
package slow_fast_pkg;

  localparam int unsigned DW_DEF     = 12;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned SETTLE_DEF = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } state_e;

endpackage

// File: rtl/sf_fifo.sv
// Sample FIFO with registered head output.
// Pointers are one bit wider than the address and wrap modulo 2*DEPTH.
// dout/dout_valid are reloaded from storage one cycle after any pointer
// change, so a sample pushed into an empty FIFO is visible the next cycle.
module sf_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          wr_en;

  // Pointer update, storage write and next head-register value
  always_comb begin
    full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty  = (wr_q == rd_q);
    wr_en  = push && (!full || pop);
    rd_d   = rd_q + (AW+1)'(pop);
    wr_d   = wr_q + (AW+1)'(wr_en);
    mem_d  = mem_q;
    if (wr_en) begin
      mem_d[wr_q[AW-1:0]] = din;
    end
    // Head is judged against the write pointer before this cycle's push,
    // which is what gives the one-cycle push-to-visible latency.
    dout_valid_d = (wr_q != rd_d);
    dout_d       = dout_valid_d ? mem_q[rd_d[AW-1:0]] : dout_q;
  end

  // Pointer and head-register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= '0;
      rd_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Sample storage (contents are don't-care until written)
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: rtl/slow_fast_xfer.sv
// Transfers samples launched on slow_clk into the clk domain.
// slow_clk is synchronized and edge-detected, a settle delay is waited,
// then din is pushed into sf_fifo. ovf flags ignored edges and drops.
// Optional: define SLOW_FAST_XFER_DROPCNT_EN to add the drop_cnt output.
module slow_fast_xfer
  import slow_fast_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          slow_clk,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          ovf,
  input  logic          ovf_clr
`ifdef SLOW_FAST_XFER_DROPCNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam logic [2:0] SETTLE_M1 = 3'(SETTLE) - 3'd1;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic       ovf_q, ovf_d;
  logic       edge_p, busy_hit, push, pop, drop, ovf_event;
  logic       fifo_full, fifo_empty;

  // Synchronizer, edge detect, capture FSM and sticky error flag
  always_comb begin
    sync1_d  = slow_clk;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    edge_p   = sync2_q && !hist_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    busy_hit = 1'b0;
    // The FIFO write happens on the edge that enters CAPT, so the sample
    // lands SETTLE edges after the edge pulse is acted on; CAPT itself is
    // the one-cycle recovery slot before IDLE.
    unique case (state_q)
      IDLE: begin
        if (edge_p) begin
          if (SETTLE == 0) begin
            state_d = CAPT;
            push    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = SETTLE_M1;
          end
        end
      end
      WAIT: begin
        busy_hit = edge_p;
        if (cnt_q == 3'd0) begin
          state_d = CAPT;
          push    = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      CAPT: begin
        busy_hit = edge_p;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pop       = dout_valid && dout_ready && !fifo_empty;
    drop      = push && fifo_full && !pop;
    ovf_event = busy_hit || drop;
    ovf_d     = ovf_event || (ovf_q && !ovf_clr);
  end

  // Control state; synchronizer resets high so a high slow_clk is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  sf_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .din        (din),
    .pop        (pop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign ovf = ovf_q;

`ifdef SLOW_FAST_XFER_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of error events; a same-cycle event beats the clear
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_event) begin
      if (ovf_clr) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_slow_fast_xfer.sv
// Testbench for slow_fast_xfer: two instances (SETTLE=1 and SETTLE=7)
// share stimulus; each has a queue-based timing model and a scoreboard
// monitor. Directed scenarios first, then randomized slow periods/ready.
module tb_slow_fast_xfer;

  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [DW-1:0] v;
    int            t;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          slow_clk = 1'b0;
  logic [DW-1:0] din = '0;
  logic          dout_ready = 1'b1;
  logic          ovf_clr = 1'b0;

  logic [DW-1:0] dout [2];
  logic          dv   [2];
  logic          ovf  [2];
  logic [7:0]    dcnt [2];
  int            sb_left [2];

  int vec  = 0;
  int errs = 0;
  bit rnd  = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int unsigned ST = (g == 0) ? 1 : 7;

    slow_fast_xfer #(
      .DW     (DW),
      .DEPTH  (DEPTH),
      .SETTLE (ST)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .slow_clk   (slow_clk),
      .din        (din),
      .dout       (dout[g]),
      .dout_valid (dv[g]),
      .dout_ready (dout_ready),
      .ovf        (ovf[g]),
      .ovf_clr    (ovf_clr)
`ifdef SLOW_FAST_XFER_DROPCNT_EN
      ,
      .drop_cnt   (dcnt[g])
`endif
    );

`ifndef SLOW_FAST_XFER_DROPCNT_EN
    assign dcnt[g] = '0;
`endif

    // Reference model: sampled-edge timestamps, a busy window per accepted
    // capture, and a FIFO of (sample, push time) entries.
    ent_t          mq [$];
    logic [DW-1:0] sb [$];
    int            pq [$];
    int            t = 0, last_c = -100;
    bit            cap_pend = 0, prev = 1, mvalid = 0, movf = 0;
    int            mcnt = 0;

    always @(posedge clk or negedge rst_n) begin
      bit ev, pop, full;
      if (!rst_n) begin
        mq.delete(); sb.delete(); pq.delete();
        cap_pend = 0; last_c = -100; prev = 1;
        mvalid = 0; movf = 0; mcnt = 0;
      end else begin
        t    = t + 1;
        ev   = 0;
        full = (mq.size() == DEPTH);
        pop  = mvalid && dout_ready;
        if (pop) void'(mq.pop_front());
        // edge acted on two cycles after first high sample
        if (pq.size() > 0 && pq[0] == t) begin
          void'(pq.pop_front());
          if (cap_pend || t <= last_c + 1) ev = 1;
          else begin
            last_c   = t + ST;
            cap_pend = 1;
          end
        end
        if (cap_pend && last_c == t) begin
          cap_pend = 0;
          if (full && !pop) ev = 1;
          else begin
            mq.push_back('{v: din, t: t});
            sb.push_back(din);
          end
        end
        if (slow_clk && !prev) pq.push_back(t + 2);
        prev   = slow_clk;
        mvalid = (mq.size() > 0) && (mq[0].t < t);
        if (ev) begin
          movf = 1;
          if (ovf_clr) mcnt = 1;
          else if (mcnt < 255) mcnt++;
        end else if (ovf_clr) begin
          movf = 0;
          mcnt = 0;
        end
      end
    end

    // Monitor: per-cycle valid/ovf checks, scoreboard check of head sample
    always @(negedge clk) begin
      vec++;
      if (dv[g] !== mvalid) begin
        errs++;
        $display("FAIL valid[%0d] t=%0d got=%0b exp=%0b", g, t, dv[g], mvalid);
      end
      vec++;
      if (ovf[g] !== movf) begin
        errs++;
        $display("FAIL ovf[%0d] t=%0d got=%0b exp=%0b", g, t, ovf[g], movf);
      end
`ifdef SLOW_FAST_XFER_DROPCNT_EN
      vec++;
      if (dcnt[g] !== 8'(mcnt)) begin
        errs++;
        $display("FAIL drop_cnt[%0d] t=%0d got=%0d exp=%0d", g, t, dcnt[g], mcnt);
      end
`endif
      if (rst_n && dv[g]) begin
        vec++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL dout[%0d] t=%0d got=%h exp=<none>", g, t, dout[g]);
        end else begin
          if (dout[g] !== sb[0]) begin
            errs++;
            $display("FAIL dout[%0d] t=%0d got=%h exp=%h", g, t, dout[g], sb[0]);
          end
          if (dout_ready) void'(sb.pop_front());
        end
      end
      sb_left[g] = sb.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      dout_ready = ($urandom_range(0, 9) < 7);
      ovf_clr    = ($urandom_range(0, 29) == 0);
    end
  endtask

  task automatic slow_edge(input logic [DW-1:0] v, input int hi, input int lo);
    din      = v;
    slow_clk = 1'b1;
    repeat (hi) tick();
    slow_clk = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    vec++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic clr_pulse();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
  endtask

  initial begin
    // reset, single edge
    repeat (4) tick();
    chk("rst_valid0", int'(dv[0]), 0);
    chk("rst_ovf1", int'(ovf[1]), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    slow_edge(12'hA5C, 6, 14);
    chk("single_ovf0", int'(ovf[0]), 0);

    // full FIFO: 1..5 with consumer stalled
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) slow_edge(DW'(i), 6, 14);
    chk("full_ovf0", int'(ovf[0]), 1);
    chk("full_ovf1", int'(ovf[1]), 1);
`ifdef SLOW_FAST_XFER_DROPCNT_EN
    chk("full_dcnt0", int'(dcnt[0]), 1);
`endif
    dout_ready = 1'b1;
    repeat (10) tick();
    clr_pulse();

    // full with simultaneous pop at the SETTLE=1 capture edge
    dout_ready = 1'b0;
    for (int i = 1; i <= 4; i++) slow_edge(DW'(i), 6, 14);
    din      = 12'd7;
    slow_clk = 1'b1;
    repeat (3) tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    repeat (2) tick();
    slow_clk = 1'b0;
    repeat (14) tick();
    chk("fullpop_ovf0", int'(ovf[0]), 0);
    chk("fullpop_ovf1", int'(ovf[1]), 0);
    dout_ready = 1'b1;
    repeat (10) tick();

    // short period: second edge inside WAIT/CAPT
    slow_edge(12'h111, 1, 1);
    slow_edge(12'h222, 6, 30);
    chk("short_ovf0", int'(ovf[0]), 1);
    chk("short_ovf1", int'(ovf[1]), 1);
    clr_pulse();
    chk("clr_ovf1", int'(ovf[1]), 0);
`ifdef SLOW_FAST_XFER_DROPCNT_EN
    chk("clr_dcnt1", int'(dcnt[1]), 0);
`endif

    // reset released with slow_clk high
    slow_clk = 1'b1;
    rst_n    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("hi_rst_valid0", int'(dv[0]), 0);
    chk("hi_rst_valid1", int'(dv[1]), 0);
    slow_clk = 1'b0;
    repeat (3) tick();
    slow_edge(12'h3C3, 6, 14);

    // mid-transfer reset with entries buffered
    dout_ready = 1'b0;
    slow_edge(12'h0AA, 6, 14);
    slow_edge(12'h0BB, 6, 14);
    din      = 12'h0CC;
    slow_clk = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid1", int'(dv[1]), 0);
    rst_n = 1'b1;
    slow_clk = 1'b0;
    dout_ready = 1'b1;
    repeat (30) tick();
    chk("midrst_idle0", int'(dv[0]), 0);

    // randomized periods, consumer stalls and clears
    rnd = 1'b1;
    for (int n = 0; n < 250; n++) begin
      slow_edge(DW'($urandom), $urandom_range(1, 10), $urandom_range(1, 10));
    end
    rnd        = 1'b0;
    dout_ready = 1'b1;
    ovf_clr    = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    #1;
    chk("drained0", sb_left[0], 0);
    chk("drained1", sb_left[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
